// File: rtl/digital_clock_pkg.sv
// Shared limits, ring FSM states and binary-to-BCD helper
// for the digital clock with alarm.
package digital_clock_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } ring_state_e;

    // Valid for 0..63; returns {tens, ones}
    function automatic logic [7:0] bin2bcd(input logic [5:0] b);
        logic [5:0] t;
        logic [5:0] o;
        t = b / 6'd10;
        o = b - t * 6'd10;
        return {t[3:0], o[3:0]};
    endfunction

endpackage

// File: rtl/digital_clock_alarm_bcd_hour_12h.sv
// Combinational 24 h BCD hour to display hour (12/24 h) plus PM flag.
module bcd_hour_12h
    import digital_clock_pkg::*;
(
    input  logic       mode_12h,
    input  logic [3:0] h1_in,
    input  logic [3:0] h0_in,
    output logic [3:0] h1_out,
    output logic [3:0] h0_out,
    output logic       pm
);

    logic [4:0] hb;
    logic [7:0] conv;

    always_comb begin
        hb     = {1'b0, h1_in} * 5'd10 + {1'b0, h0_in};
        pm     = (hb >= 5'd12);
        conv   = {h1_in, h0_in};
        if (mode_12h) begin
            if (hb == 5'd0) begin
                conv = 8'h12;
            end else if (hb > 5'd12) begin
                conv = bin2bcd({1'b0, hb - 5'd12});
            end
        end
        h1_out = conv[7:4];
        h0_out = conv[3:0];
    end

endmodule

// File: rtl/digital_clock_alarm.sv
// BCD time-of-day counter with validated load, alarm ring FSM,
// day-wrap pulse and 12/24 h display selection.
module digital_clock_alarm
    import digital_clock_pkg::*;
#(
    parameter int ALARM_LEN = 10,
    parameter int RING_W    = 6
) (
    input  logic       CLK_1Hz,
    input  logic       RESET,
    input  logic       EN,
    input  logic       MODE_12H,
    input  logic       LOAD,
    input  logic [4:0] LOAD_HOUR,
    input  logic [5:0] LOAD_MIN,
    input  logic [5:0] LOAD_SEC,
    input  logic       ALARM_SET,
    input  logic [4:0] ALARM_HOUR,
    input  logic [5:0] ALARM_MIN,
    input  logic       ALARM_EN,
    input  logic       ALARM_ACK,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hour0,
    output logic [3:0] hour1,
    output logic       PM,
    output logic       ALARM,
    output logic       DAY_TICK,
    output logic       LOAD_ERR
);

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(ALARM_LEN - 1);

    logic [3:0] sec0_q, sec1_q, min0_q, min1_q, hour0_q, hour1_q;
    logic [3:0] sec0_d, sec1_d, min0_d, min1_d, hour0_d, hour1_d;
    logic [7:0] alm_hr_q, alm_min_q, alm_hr_d, alm_min_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    ring_state_e ring_q, ring_d;
    logic day_tick_q, day_tick_d, load_err_q, load_err_d;

    logic load_ok, alm_ok, step, trigger;
    logic c_sec, c_min, c_day;
    logic [7:0] ld_h, ld_m, ld_s;

    always_comb begin
        sec0_d     = sec0_q;
        sec1_d     = sec1_q;
        min0_d     = min0_q;
        min1_d     = min1_q;
        hour0_d    = hour0_q;
        hour1_d    = hour1_q;
        alm_hr_d   = alm_hr_q;
        alm_min_d  = alm_min_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        step       = 1'b0;

        load_ok = (LOAD_HOUR <= HOUR_MAX) && (LOAD_MIN <= MIN_MAX)
                  && (LOAD_SEC <= SEC_MAX);
        alm_ok  = (ALARM_HOUR <= HOUR_MAX) && (ALARM_MIN <= MIN_MAX);
        ld_h    = bin2bcd({1'b0, LOAD_HOUR});
        ld_m    = bin2bcd(LOAD_MIN);
        ld_s    = bin2bcd(LOAD_SEC);

        c_sec = (sec0_q == 4'd9) && (sec1_q == 4'd5);
        c_min = c_sec && (min0_q == 4'd9) && (min1_q == 4'd5);
        c_day = c_min && (hour1_q == 4'd2) && (hour0_q == 4'd3);

        // An invalid LOAD still blocks counting on that edge
        if (LOAD) begin
            if (load_ok) begin
                {hour1_d, hour0_d} = ld_h;
                {min1_d, min0_d}   = ld_m;
                {sec1_d, sec0_d}   = ld_s;
            end
        end else if (EN) begin
            step   = 1'b1;
            sec0_d = (sec0_q == 4'd9) ? 4'd0 : sec0_q + 4'd1;
            if (sec0_q == 4'd9) begin
                sec1_d = (sec1_q == 4'd5) ? 4'd0 : sec1_q + 4'd1;
            end
            if (c_sec) begin
                min0_d = (min0_q == 4'd9) ? 4'd0 : min0_q + 4'd1;
                if (min0_q == 4'd9) begin
                    min1_d = (min1_q == 4'd5) ? 4'd0 : min1_q + 4'd1;
                end
            end
            if (c_day) begin
                hour1_d = 4'd0;
                hour0_d = 4'd0;
            end else if (c_min) begin
                if (hour0_q == 4'd9) begin
                    hour0_d = 4'd0;
                    hour1_d = hour1_q + 4'd1;
                end else begin
                    hour0_d = hour0_q + 4'd1;
                end
            end
        end

        if (ALARM_SET && alm_ok) begin
            alm_hr_d  = bin2bcd({1'b0, ALARM_HOUR});
            alm_min_d = bin2bcd(ALARM_MIN);
        end

        day_tick_d = step && c_day;
        load_err_d = (LOAD && !load_ok) || (ALARM_SET && !alm_ok);
        trigger    = step && ALARM_EN
                     && ({hour1_d, hour0_d, min1_d, min0_d, sec1_d, sec0_d}
                         == {alm_hr_q, alm_min_q, 8'h00});

        unique case (ring_q)
            IDLE: begin
                if (trigger) begin
                    ring_d     = RING;
                    ring_cnt_d = '0;
                end
            end
            RING: begin
                if (ALARM_ACK || !ALARM_EN) begin
                    ring_d = IDLE;
                end else if (EN) begin
                    if (ring_cnt_q == RING_LAST) begin
                        ring_d = IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
            end
            default: ring_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_1Hz or posedge RESET) begin
        if (RESET) begin
            sec0_q     <= '0;
            sec1_q     <= '0;
            min0_q     <= '0;
            min1_q     <= '0;
            hour0_q    <= '0;
            hour1_q    <= '0;
            alm_hr_q   <= '0;
            alm_min_q  <= '0;
            ring_q     <= IDLE;
            ring_cnt_q <= '0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sec0_q     <= sec0_d;
            sec1_q     <= sec1_d;
            min0_q     <= min0_d;
            min1_q     <= min1_d;
            hour0_q    <= hour0_d;
            hour1_q    <= hour1_d;
            alm_hr_q   <= alm_hr_d;
            alm_min_q  <= alm_min_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_hour_12h u_hour (
        .mode_12h (MODE_12H),
        .h1_in    (hour1_q),
        .h0_in    (hour0_q),
        .h1_out   (hour1),
        .h0_out   (hour0),
        .pm       (PM)
    );

    assign sec0     = sec0_q;
    assign sec1     = sec1_q;
    assign min0     = min0_q;
    assign min1     = min1_q;
    assign ALARM    = (ring_q == RING);
    assign DAY_TICK = day_tick_q;
    assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Directed-vector bench for digital_clock_alarm.
module tb_digital_clock_alarm;

    logic       CLK_1Hz = 1'b0;
    logic       RESET, EN, MODE_12H, LOAD, ALARM_SET, ALARM_EN, ALARM_ACK;
    logic [4:0] LOAD_HOUR, ALARM_HOUR;
    logic [5:0] LOAD_MIN, LOAD_SEC, ALARM_MIN;
    logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
    logic       PM, ALARM, DAY_TICK, LOAD_ERR;

    int n_vec = 0;
    int n_err = 0;
    int ring_len;

    always #5 CLK_1Hz = ~CLK_1Hz;

    digital_clock_alarm #(.ALARM_LEN(10), .RING_W(6)) dut (
        .CLK_1Hz    (CLK_1Hz),
        .RESET      (RESET),
        .EN         (EN),
        .MODE_12H   (MODE_12H),
        .LOAD       (LOAD),
        .LOAD_HOUR  (LOAD_HOUR),
        .LOAD_MIN   (LOAD_MIN),
        .LOAD_SEC   (LOAD_SEC),
        .ALARM_SET  (ALARM_SET),
        .ALARM_HOUR (ALARM_HOUR),
        .ALARM_MIN  (ALARM_MIN),
        .ALARM_EN   (ALARM_EN),
        .ALARM_ACK  (ALARM_ACK),
        .sec0       (sec0),
        .sec1       (sec1),
        .min0       (min0),
        .min1       (min1),
        .hour0      (hour0),
        .hour1      (hour1),
        .PM         (PM),
        .ALARM      (ALARM),
        .DAY_TICK   (DAY_TICK),
        .LOAD_ERR   (LOAD_ERR)
    );

    function automatic logic [23:0] tnow();
        return {hour1, hour0, min1, min0, sec1, sec0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_1Hz);
        #2;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s);
        LOAD      = 1'b1;
        LOAD_HOUR = h;
        LOAD_MIN  = m;
        LOAD_SEC  = s;
        tick();
        LOAD      = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; EN = 1'b0; MODE_12H = 1'b0; LOAD = 1'b0;
        ALARM_SET = 1'b0; ALARM_EN = 1'b0; ALARM_ACK = 1'b0;
        LOAD_HOUR = '0; LOAD_MIN = '0; LOAD_SEC = '0;
        ALARM_HOUR = '0; ALARM_MIN = '0;
        #10;
        RESET = 1'b0;
        chk("reset_time", tnow(), 24'h000000);
        chk("reset_flags", {PM, ALARM, DAY_TICK, LOAD_ERR}, 4'b0000);

        // 1: free count with minute carry
        EN = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            tick();
            if (i == 58) chk("sec_58", {sec1, sec0}, 8'h58);
            if (i == 59) chk("sec_59", {sec1, sec0}, 8'h59);
            if (i == 60) chk("min_carry", tnow(), 24'h000100);
        end
        chk("t_61", tnow(), 24'h000101);

        // 2: day wrap
        do_load(5'd23, 6'd59, 6'd58);
        chk("load_2358", tnow(), 24'h235958);
        chk("dt_load", DAY_TICK, 1'b0);
        tick();
        chk("t_235959", tnow(), 24'h235959);
        tick();
        chk("wrap_time", tnow(), 24'h000000);
        chk("dt_pulse", DAY_TICK, 1'b1);
        tick();
        chk("dt_clear", DAY_TICK, 1'b0);
        chk("t_after_wrap", tnow(), 24'h000001);

        // 3: 12/24 h display
        EN = 1'b0;
        do_load(5'd13, 6'd5, 6'd0);
        chk("h24_13", {hour1, hour0, PM}, 9'h13 << 1 | 9'd1);
        MODE_12H = 1'b1;
        #1;
        chk("h12_01", {hour1, hour0, PM}, 9'h01 << 1 | 9'd1);
        chk("h12_minsec", {min1, min0, sec1, sec0}, 16'h0500);
        do_load(5'd0, 6'd0, 6'd0);
        chk("h12_midnight", {hour1, hour0, PM}, 9'h12 << 1);
        chk("dt_load0", DAY_TICK, 1'b0);
        do_load(5'd12, 6'd34, 6'd56);
        chk("h12_noon", {hour1, hour0, PM}, 9'h12 << 1 | 9'd1);
        MODE_12H = 1'b0;
        #1;
        chk("h24_12", tnow(), 24'h123456);

        // 4: rejected loads and alarm set
        do_load(5'd24, 6'd0, 6'd0);
        chk("bad_hour_t", tnow(), 24'h123456);
        chk("bad_hour_err", LOAD_ERR, 1'b1);
        tick();
        chk("err_clear", LOAD_ERR, 1'b0);
        do_load(5'd1, 6'd60, 6'd0);
        chk("bad_min_t", tnow(), 24'h123456);
        chk("bad_min_err", LOAD_ERR, 1'b1);
        ALARM_SET = 1'b1; ALARM_HOUR = 5'd7; ALARM_MIN = 6'd30;
        tick();
        chk("alm_ok_err", LOAD_ERR, 1'b0);
        ALARM_MIN = 6'd61;
        do_load(5'd7, 6'd29, 6'd58);
        ALARM_SET = 1'b0;
        chk("both_load_t", tnow(), 24'h072958);
        chk("bad_alm_err", LOAD_ERR, 1'b1);
        tick();
        chk("err_once", LOAD_ERR, 1'b0);

        // 5: alarm ring for full length, then with ACK
        ALARM_EN = 1'b1;
        EN = 1'b1;
        tick();
        chk("pre_alarm", {tnow(), 7'd0, ALARM}, {24'h072959, 8'h00});
        tick();
        chk("alarm_rise", {tnow(), 7'd0, ALARM}, {24'h073000, 8'h01});
        ring_len = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ALARM) break;
            ring_len++;
        end
        chk("ring_len", ring_len, 10);
        chk("ring_end_t", tnow(), 24'h073010);
        EN = 1'b0;
        do_load(5'd7, 6'd30, 6'd0);
        chk("load_no_trig", ALARM, 1'b0);
        do_load(5'd7, 6'd29, 6'd59);
        EN = 1'b1;
        tick();
        chk("ack_rise", ALARM, 1'b1);
        tick();
        tick();
        chk("ack_ring3", ALARM, 1'b1);
        ALARM_ACK = 1'b1;
        tick();
        ALARM_ACK = 1'b0;
        chk("ack_fall", ALARM, 1'b0);

        // 6: async reset mid-cycle, then freeze
        do_load(5'd7, 6'd29, 6'd59);
        tick();
        chk("pre_rst_alarm", ALARM, 1'b1);
        #1;
        RESET = 1'b1;
        #1;
        chk("async_rst_t", tnow(), 24'h000000);
        chk("async_rst_f", {PM, ALARM, DAY_TICK, LOAD_ERR}, 4'b0000);
        @(negedge CLK_1Hz);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_cnt", tnow(), 24'h000003);
        EN = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("frozen", tnow(), 24'h000003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
